// File: rtl/plab5_mcore_xbar_pkg.sv
// Shared helpers for the domain-separated memory crossbar.
//  - f_cnt_w     : width of the slot-timer counter for a given slot length
//  - f_*_lsb     : bit offsets of the fields inside one buffer entry,
//                  laid out as {ctrl, data, src} with src in the low bits
//  - f_entry_w   : total width of one buffer entry (valid bit kept apart)
package plab5_mcore_xbar_pkg;

  function automatic int f_cnt_w(input int slot_cycles);
    return (slot_cycles > 1) ? $clog2(slot_cycles) : 1;
  endfunction

  function automatic int f_src_lsb();
    return 0;
  endfunction

  function automatic int f_data_lsb(input int ns);
    return ns;
  endfunction

  function automatic int f_ctrl_lsb(input int ns, input int dbits);
    return ns + dbits;
  endfunction

  function automatic int f_entry_w(input int ns, input int cbits, input int dbits);
    return ns + cbits + dbits;
  endfunction

endpackage

// File: rtl/plab5_mcore_xbar_rr_arb.sv
// N-way round-robin arbiter.
//  clk, reset : clock, synchronous active-high reset (pointer returns to 0)
//  req[p_n]   : request vector
//  en         : commit the current pick; pointer moves to winner+1 mod p_n
//  gnt[p_n]   : one-hot pick, scanning upward from the pointer. The pick is
//               shown even when en=0 so callers can gate it themselves.
module plab5_mcore_xbar_rr_arb #(
  parameter int p_n = 4
)(
  input  logic           clk,
  input  logic           reset,
  input  logic [p_n-1:0] req,
  input  logic           en,
  output logic [p_n-1:0] gnt
);

  localparam int lp_pw = (p_n > 1) ? $clog2(p_n) : 1;
  localparam logic [lp_pw-1:0] lp_last = lp_pw'(p_n - 1);

  logic [lp_pw-1:0] r_ptr;
  logic [lp_pw-1:0] w_win;
  logic             w_any;

  always_comb begin
    gnt   = '0;
    w_win = '0;
    w_any = 1'b0;
    for (int k = 0; k < p_n; k++) begin
      int v_idx;
      v_idx = (int'(r_ptr) + k) % p_n;
      if (!w_any && req[v_idx]) begin
        w_any      = 1'b1;
        gnt[v_idx] = 1'b1;
        w_win      = lp_pw'(v_idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr <= '0;
    end else if (en && w_any) begin
      r_ptr <= (w_win == lp_last) ? '0 : w_win + 1'b1;
    end
  end

endmodule

// File: rtl/plab5_mcore_mem_xbar_dom_sep.sv
// N-port memory crossbar with one single-entry buffer per (output, domain).
//  clk, reset        : clock, synchronous active-high reset
//  mode              : 0 = outputs shared between domains, 1 = time-sliced
//  in_*              : per-input valid/ready, split ctrl/data payload,
//                      domain bit and destination index
//  out_*             : per-output valid/ready, payload, domain, source index
//  slot_domain       : domain owning the current time slot
//  drop_err          : sticky, set when a message with dest>=N is consumed
//
// Handshake: a transfer happens on a port in a cycle where valid and ready
// are both 1. in_rdy may depend on out_rdy (a full buffer that is being
// drained accepts in the same cycle), but no output payload or out_val
// depends combinationally on any input message. In mode=1 out_val may drop
// without a transfer when the slot changes; sinks must not rely on it being
// held.
module plab5_mcore_mem_xbar_dom_sep
  import plab5_mcore_xbar_pkg::*;
#(
  parameter int p_num_ports   = 4,
  parameter int p_ctrl_nbits  = 46,
  parameter int p_data_nbits  = 32,
  parameter int p_slot_cycles = 4,
  parameter int p_single_bank = 0,
  localparam int ns = $clog2(p_num_ports)
)(
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              mode,
  input  logic [p_num_ports-1:0]            in_val,
  output logic [p_num_ports-1:0]            in_rdy,
  input  logic [p_num_ports*p_ctrl_nbits-1:0] in_msg_control,
  input  logic [p_num_ports*p_data_nbits-1:0] in_msg_data,
  input  logic [p_num_ports-1:0]            in_domain,
  input  logic [p_num_ports*ns-1:0]         in_dest,
  output logic [p_num_ports-1:0]            out_val,
  input  logic [p_num_ports-1:0]            out_rdy,
  output logic [p_num_ports*p_ctrl_nbits-1:0] out_msg_control,
  output logic [p_num_ports*p_data_nbits-1:0] out_msg_data,
  output logic [p_num_ports-1:0]            out_domain,
  output logic [p_num_ports*ns-1:0]         out_src,
  output logic                              slot_domain,
  output logic                              drop_err
);

  localparam int lp_n        = p_num_ports;
  localparam int lp_c        = p_ctrl_nbits;
  localparam int lp_d        = p_data_nbits;
  localparam int lp_cw       = f_cnt_w(p_slot_cycles);
  localparam int lp_ew       = f_entry_w(ns, lp_c, lp_d);
  localparam int lp_src_lsb  = f_src_lsb();
  localparam int lp_data_lsb = f_data_lsb(ns);
  localparam int lp_ctrl_lsb = f_ctrl_lsb(ns, lp_d);
  localparam logic [lp_cw-1:0] lp_cnt_last = lp_cw'(p_slot_cycles - 1);
  localparam logic [ns:0]      lp_n_ext    = (ns + 1)'(p_num_ports);

  // Slot timer: free-running, independent of mode, so switching mode never
  // disturbs the slot phase.
  logic [lp_cw-1:0] r_cnt;
  logic             r_slot_dom;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt      <= '0;
      r_slot_dom <= 1'b0;
    end else if (r_cnt == lp_cnt_last) begin
      r_cnt      <= '0;
      r_slot_dom <= ~r_slot_dom;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign slot_domain = r_slot_dom;

  // Effective destinations and out-of-range drops.
  logic [ns-1:0]   w_dest [lp_n];
  logic [lp_n-1:0] w_drop;

  for (genvar i = 0; i < lp_n; i++) begin : g_in
    assign w_dest[i] = (p_single_bank != 0) ? '0 : in_dest[i*ns +: ns];
    assign w_drop[i] = in_val[i] & ({1'b0, w_dest[i]} >= lp_n_ext);
  end

  logic r_drop_err;

  always_ff @(posedge clk) begin
    if (reset) r_drop_err <= 1'b0;
    else       r_drop_err <= r_drop_err | (|w_drop);
  end

  assign drop_err = r_drop_err;

  // Accepted-grant vectors, one per buffer, ORed into in_rdy below.
  logic [lp_n-1:0] w_acc [lp_n][2];

  for (genvar j = 0; j < lp_n; j++) begin : g_out
    logic [1:0]       w_vld_j;
    logic [1:0]       w_deq_j;
    logic [lp_ew-1:0] w_ent_j [2];
    logic [1:0]       w_eg_gnt;
    logic             w_eg_adv;
    logic             w_sel;
    logic             w_oval;

    for (genvar d = 0; d < 2; d++) begin : g_dom
      logic [lp_n-1:0]  w_req;
      logic [lp_n-1:0]  w_gnt;
      logic             w_may;
      logic [lp_ew-1:0] w_load_ent;
      logic             r_vld;
      logic [lp_ew-1:0] r_ent;

      always_comb begin
        for (int i = 0; i < lp_n; i++) begin
          w_req[i] = in_val[i] & (in_domain[i] == 1'(d)) &
                     (w_dest[i] == ns'(j)) & ~w_drop[i];
        end
      end

      // Refill in the same cycle as the drain keeps one message per cycle.
      assign w_may = ~r_vld | w_deq_j[d];

      plab5_mcore_xbar_rr_arb #(.p_n(lp_n)) u_in_arb (
        .clk   (clk),
        .reset (reset),
        .req   (w_req),
        .en    (w_may),
        .gnt   (w_gnt)
      );

      assign w_acc[j][d] = w_gnt & {lp_n{w_may & ~reset}};

      always_comb begin
        w_load_ent = '0;
        for (int i = 0; i < lp_n; i++) begin
          if (w_gnt[i]) begin
            w_load_ent[lp_ctrl_lsb +: lp_c] = in_msg_control[i*lp_c +: lp_c];
            w_load_ent[lp_data_lsb +: lp_d] = in_msg_data[i*lp_d +: lp_d];
            w_load_ent[lp_src_lsb  +: ns]   = ns'(i);
          end
        end
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          r_vld <= 1'b0;
        end else if (|w_acc[j][d]) begin
          r_vld <= 1'b1;
          r_ent <= w_load_ent;
        end else if (w_deq_j[d]) begin
          r_vld <= 1'b0;
        end
      end

      assign w_vld_j[d] = r_vld;
      assign w_ent_j[d] = r_ent;
    end

    // Shared-mode egress: the 2-way pointer only moves when both domains
    // were competing, so a lone domain does not steal the other's turn.
    assign w_eg_adv = ~mode & (&w_vld_j) & w_oval & out_rdy[j];

    plab5_mcore_xbar_rr_arb #(.p_n(2)) u_eg_arb (
      .clk   (clk),
      .reset (reset),
      .req   (w_vld_j),
      .en    (w_eg_adv),
      .gnt   (w_eg_gnt)
    );

    assign w_sel  = mode ? r_slot_dom : w_eg_gnt[1];
    assign w_oval = ~reset & (mode ? w_vld_j[r_slot_dom] : (|w_vld_j));

    assign w_deq_j[0] = w_oval & out_rdy[j] & ~w_sel;
    assign w_deq_j[1] = w_oval & out_rdy[j] &  w_sel;

    assign out_val[j]                     = w_oval;
    assign out_domain[j]                  = w_sel;
    assign out_msg_control[j*lp_c +: lp_c] = w_ent_j[w_sel][lp_ctrl_lsb +: lp_c];
    assign out_msg_data[j*lp_d +: lp_d]    = w_ent_j[w_sel][lp_data_lsb +: lp_d];
    assign out_src[j*ns +: ns]             = w_ent_j[w_sel][lp_src_lsb +: ns];
  end

  always_comb begin
    in_rdy = w_drop & {lp_n{~reset}};
    for (int j = 0; j < lp_n; j++) begin
      for (int d = 0; d < 2; d++) begin
        in_rdy = in_rdy | w_acc[j][d];
      end
    end
  end

endmodule

// File: tb/tb_plab5_mcore_mem_xbar_dom_sep.sv
module tb_plab5_mcore_mem_xbar_dom_sep;

  localparam int P_N = 4;
  localparam int P_C = 46;
  localparam int P_D = 32;
  localparam int P_S = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // ---------------- main DUT (N=4) ----------------
  logic               mode;
  logic [P_N-1:0]     in_val, in_rdy, in_domain, out_val, out_rdy, out_domain;
  logic [P_N*P_C-1:0] in_msg_control, out_msg_control;
  logic [P_N*P_D-1:0] in_msg_data, out_msg_data;
  logic [P_N*2-1:0]   in_dest, out_src;
  logic               slot_domain, drop_err;

  plab5_mcore_mem_xbar_dom_sep #(
    .p_num_ports(P_N), .p_ctrl_nbits(P_C), .p_data_nbits(P_D),
    .p_slot_cycles(P_S), .p_single_bank(0)
  ) dut (
    .clk(clk), .reset(reset), .mode(mode),
    .in_val(in_val), .in_rdy(in_rdy),
    .in_msg_control(in_msg_control), .in_msg_data(in_msg_data),
    .in_domain(in_domain), .in_dest(in_dest),
    .out_val(out_val), .out_rdy(out_rdy),
    .out_msg_control(out_msg_control), .out_msg_data(out_msg_data),
    .out_domain(out_domain), .out_src(out_src),
    .slot_domain(slot_domain), .drop_err(drop_err)
  );

  // ---------------- second DUT (N=3) for out-of-range dest ----------------
  logic [2:0]   t_in_val, t_in_rdy, t_in_domain, t_out_val, t_out_rdy, t_out_domain;
  logic [137:0] t_in_ctrl, t_out_ctrl;
  logic [95:0]  t_in_data, t_out_data;
  logic [5:0]   t_in_dest, t_out_src;
  logic         t_slot_domain, t_drop_err;

  plab5_mcore_mem_xbar_dom_sep #(
    .p_num_ports(3), .p_ctrl_nbits(P_C), .p_data_nbits(P_D),
    .p_slot_cycles(P_S), .p_single_bank(0)
  ) dut3 (
    .clk(clk), .reset(reset), .mode(1'b0),
    .in_val(t_in_val), .in_rdy(t_in_rdy),
    .in_msg_control(t_in_ctrl), .in_msg_data(t_in_data),
    .in_domain(t_in_domain), .in_dest(t_in_dest),
    .out_val(t_out_val), .out_rdy(t_out_rdy),
    .out_msg_control(t_out_ctrl), .out_msg_data(t_out_data),
    .out_domain(t_out_domain), .out_src(t_out_src),
    .slot_domain(t_slot_domain), .drop_err(t_drop_err)
  );

  // ---------------- scoreboard state ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [1:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Buffers as plain arrays; slot ownership derived from cycles since reset.
  bit          m_v    [P_N][2];
  logic [45:0] m_ctrl [P_N][2];
  logic [31:0] m_data [P_N][2];
  int          m_src  [P_N][2];
  int          m_ptr  [P_N][2];
  bit          m_eg   [P_N];
  int          m_cyc;

  logic [P_N-1:0] e_rdy, e_val;
  int             e_dom  [P_N];
  bit             e_both [P_N];
  bit             e_deq  [P_N][2];
  bit             e_load [P_N][2];
  int             e_win  [P_N][2];

  task automatic model_eval();
    int sd;
    sd = (m_cyc / P_S) % 2;
    e_rdy = '0;
    e_val = '0;
    for (int j = 0; j < P_N; j++) begin
      e_both[j] = m_v[j][0] && m_v[j][1];
      e_dom[j]  = 0;
      for (int d = 0; d < 2; d++) begin
        e_deq[j][d] = 0; e_load[j][d] = 0; e_win[j][d] = -1;
      end
    end
    if (reset) return;
    for (int j = 0; j < P_N; j++) begin
      if (mode) begin
        e_dom[j] = sd;
        e_val[j] = m_v[j][sd];
      end else if (e_both[j]) begin
        e_dom[j] = int'(m_eg[j]);
        e_val[j] = 1'b1;
      end else begin
        e_dom[j] = m_v[j][1] ? 1 : 0;
        e_val[j] = m_v[j][0] || m_v[j][1];
      end
      for (int d = 0; d < 2; d++)
        e_deq[j][d] = e_val[j] && out_rdy[j] && (e_dom[j] == d);
    end
    for (int j = 0; j < P_N; j++) begin
      for (int d = 0; d < 2; d++) begin
        for (int k = 0; k < P_N; k++) begin
          int i;
          i = (m_ptr[j][d] + k) % P_N;
          if (e_win[j][d] < 0 && in_val[i] && int'(in_domain[i]) == d &&
              int'(in_dest[i*2 +: 2]) == j)
            e_win[j][d] = i;
        end
        e_load[j][d] = (e_win[j][d] >= 0) && (!m_v[j][d] || e_deq[j][d]);
        if (e_load[j][d]) e_rdy[e_win[j][d]] = 1'b1;
      end
    end
  endtask

  task automatic model_commit();
    if (reset) begin
      for (int j = 0; j < P_N; j++) begin
        m_eg[j] = 0;
        for (int d = 0; d < 2; d++) begin
          m_v[j][d] = 0; m_ptr[j][d] = 0;
        end
      end
      m_cyc = 0;
      return;
    end
    for (int j = 0; j < P_N; j++) begin
      if (!mode && e_both[j] && (e_deq[j][0] || e_deq[j][1])) m_eg[j] = !m_eg[j];
      for (int d = 0; d < 2; d++) begin
        if (e_deq[j][d]) m_v[j][d] = 0;
        if (e_load[j][d]) begin
          int i;
          i = e_win[j][d];
          m_v[j][d]    = 1;
          m_ctrl[j][d] = in_msg_control[i*P_C +: P_C];
          m_data[j][d] = in_msg_data[i*P_D +: P_D];
          m_src[j][d]  = i;
          m_ptr[j][d]  = (i + 1) % P_N;
        end
      end
    end
    m_cyc++;
  endtask

  task automatic check_outputs();
    chk("in_rdy", 64'(in_rdy), 64'(e_rdy));
    chk("out_val", 64'(out_val), 64'(e_val));
    chk("slot_domain", 64'(slot_domain), 64'((m_cyc / P_S) % 2));
    chk("drop_err", 64'(drop_err), 64'(0));
    for (int j = 0; j < P_N; j++) begin
      if (e_val[j]) begin
        int d;
        d = e_dom[j];
        chk("out_domain", 64'(out_domain[j]), 64'(d));
        chk("out_ctrl", 64'(out_msg_control[j*P_C +: P_C]), 64'(m_ctrl[j][d]));
        chk("out_data", 64'(out_msg_data[j*P_D +: P_D]), 64'(m_data[j][d]));
        chk("out_src", 64'(out_src[j*2 +: 2]), 64'(m_src[j][d]));
      end
    end
  endtask

  // One clock: compare mid-cycle, commit the model on the edge, then return
  // just after the edge so drivers can change inputs.
  task automatic cycle();
    @(negedge clk);
    model_eval();
    check_outputs();
    @(posedge clk);
    model_commit();
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    in_val = '0; in_domain = '0; in_dest = '0;
    in_msg_control = '0; in_msg_data = '0;
    t_in_val = '0; t_in_domain = '0; t_in_dest = '0;
    t_in_ctrl = '0; t_in_data = '0;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    idle_inputs();
    cycle();
    reset = 1'b0;
  endtask

  task automatic drive_port(input int i, input bit dom, input int dest,
                            input logic [45:0] c, input logic [31:0] d);
    in_val[i] = 1'b1;
    in_domain[i] = dom;
    in_dest[i*2 +: 2] = 2'(dest);
    in_msg_control[i*P_C +: P_C] = c;
    in_msg_data[i*P_D +: P_D] = d;
  endtask

  task automatic drive_random();
    for (int i = 0; i < P_N; i++) begin
      if (!in_val[i] || e_rdy[i]) begin
        in_val[i] = ($urandom_range(0, 99) < 55);
        in_domain[i] = 1'($urandom_range(0, 1));
        in_dest[i*2 +: 2] = 2'($urandom_range(0, 3));
        in_msg_control[i*P_C +: P_C] = 46'({$urandom(), $urandom()});
        in_msg_data[i*P_D +: P_D] = $urandom();
      end
    end
    out_rdy = 4'($urandom_range(0, 15)) | 4'($urandom_range(0, 15));
    if ($urandom_range(0, 63) == 0) mode = ~mode;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    reset = 1'b1;
    mode = 1'b0;
    out_rdy = '1;
    t_out_rdy = '1;
    idle_inputs();
    @(posedge clk);
    model_commit();
    #1;
    apply_reset();

    // 1: single message, one-cycle latency, fields carried through.
    drive_port(0, 1'b0, 2, 46'h1, 32'hA);
    cycle();
    in_val = '0;
    chk("t1_val", 64'(out_val[2]), 64'(1));
    chk("t1_data", 64'(out_msg_data[2*P_D +: P_D]), 64'hA);
    chk("t1_ctrl", 64'(out_msg_control[2*P_C +: P_C]), 64'h1);
    chk("t1_src", 64'(out_src[5:4]), 64'(0));
    chk("t1_dom", 64'(out_domain[2]), 64'(0));
    cycle();

    // 2: three contenders for one buffer, round-robin order without bubbles.
    apply_reset();
    drive_port(0, 1'b0, 1, 46'h10, 32'h0);
    drive_port(1, 1'b0, 1, 46'h11, 32'h1);
    drive_port(3, 1'b0, 1, 46'h13, 32'h3);
    exp_q = {2'd0, 2'd1, 2'd3, 2'd0, 2'd1, 2'd3};
    cycle();
    while (exp_q.size() > 0) begin
      chk("t2_val", 64'(out_val[1]), 64'(1));
      chk("t2_src", 64'(out_src[3:2]), 64'(exp_q.pop_front()));
      cycle();
    end
    in_val = '0;
    cycle();

    // 3: dom1 message hidden during the dom0 slot, shown after the wrap.
    apply_reset();
    mode = 1'b1;
    drive_port(2, 1'b1, 0, 46'h33, 32'h3333);
    cycle();
    in_val = '0;
    for (int k = 0; k < 3; k++) begin
      chk("t3_hidden", 64'(out_val[0]), 64'(0));
      cycle();
    end
    chk("t3_shown", 64'(out_val[0]), 64'(1));
    chk("t3_dom", 64'(out_domain[0]), 64'(1));
    chk("t3_slot", 64'(slot_domain), 64'(1));
    chk("t3_data", 64'(out_msg_data[P_D-1:0]), 64'h3333);
    cycle();

    // 4: dom0 backed up on out0 does not block or delay dom1.
    apply_reset();
    mode = 1'b1;
    out_rdy = 4'b1110;
    drive_port(0, 1'b0, 0, 46'h100, 32'h100);
    drive_port(1, 1'b1, 0, 46'h111, 32'h111);
    cycle();
    in_val[1] = 1'b0;
    chk("t4_dom0_val", 64'(out_val[0]), 64'(1));
    chk("t4_dom0_dom", 64'(out_domain[0]), 64'(0));
    repeat (3) cycle();
    chk("t4_dom1_val", 64'(out_val[0]), 64'(1));
    chk("t4_dom1_dom", 64'(out_domain[0]), 64'(1));
    chk("t4_dom1_src", 64'(out_src[1:0]), 64'(1));
    chk("t4_dom1_data", 64'(out_msg_data[P_D-1:0]), 64'h111);
    out_rdy = '1;
    in_val = '0;
    repeat (8) cycle();

    // 5: N=3 instance, dest 3 is consumed and flagged.
    apply_reset();
    mode = 1'b0;
    t_in_val = 3'b001;
    t_in_dest = 6'b000011;
    t_in_data = 96'h5;
    #1;
    chk("t5_rdy", 64'(t_in_rdy), 64'(3'b001));
    chk("t5_noval_a", 64'(t_out_val), 64'(0));
    cycle();
    t_in_val = '0;
    chk("t5_drop", 64'(t_drop_err), 64'(1));
    chk("t5_noval_b", 64'(t_out_val), 64'(0));
    repeat (3) cycle();
    chk("t5_sticky", 64'(t_drop_err), 64'(1));

    // 6: fill buffers, then reset in the middle of a handshake.
    out_rdy = '0;
    for (int i = 0; i < P_N; i++)
      drive_port(i, 1'($urandom_range(0, 1)), $urandom_range(0, 3), 46'(i), 32'(i));
    repeat (3) cycle();
    out_rdy = '1;
    reset = 1'b1;
    #1;
    chk("t6_rdy_in_reset", 64'(in_rdy), 64'(0));
    chk("t6_val_in_reset", 64'(out_val), 64'(0));
    cycle();
    reset = 1'b0;
    in_val = '0;
    #1;
    chk("t6_val", 64'(out_val), 64'(0));
    chk("t6_slot", 64'(slot_domain), 64'(0));
    chk("t6_drop", 64'(drop_err), 64'(0));
    chk("t6_drop3", 64'(t_drop_err), 64'(0));
    cycle();

    // Random traffic against the model, with occasional mode flips.
    apply_reset();
    repeat (3000) begin
      drive_random();
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
